// File: rtl/apb_master_gen2_pkg.sv
// Shared types and helpers for the APB4 master.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
// Contents: apb_state_t FSM encoding, sel_w() slave-select width helper,
// response codes packed as {timeout, err}.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  // Number of top address bits used to pick a slave. Kept at least 1 so that
  // index vectors never collapse to zero width.
  function automatic int sel_w(input int num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

  // Response codes, laid out as {rsp_timeout, rsp_err}.
  localparam logic [1:0] RSP_OKAY    = 2'b00;
  localparam logic [1:0] RSP_SLVERR  = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b11;

endpackage

// File: rtl/apb_master_gen2_rsp_mux.sv
// Per-slave APB response selector (PREADY/PRDATA/PSLVERR by slave index).
// Latency: purely combinational, zero cycles.
// Backpressure: none; unselected slaves are never observed.
// Ports: idx (slave index), PREADY/PRDATA/PSLVERR (all slaves, flattened),
//        sel_ready/sel_rdata/sel_err (selected slave only).
module apb_rsp_mux
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = sel_w(NUM_SLAVES)
) (
  input  logic [SEL_W-1:0]             idx,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PSLVERR,
  output logic                         sel_ready,
  output logic [DATA_W-1:0]            sel_rdata,
  output logic                         sel_err
);

  // NUM_SLAVES is a power of two, so every idx value names a real slave.
  always_comb begin
    sel_ready = PREADY[idx];
    sel_err   = PSLVERR[idx];
    sel_rdata = PRDATA[idx*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/apb_master_gen2.sv
// APB4 master: CPU valid/ready request -> NUM_SLAVES APB slaves -> held response.
// Latency: zero-wait transfer gives rsp_valid 3 cycles after acceptance; +1 per wait state.
// Backpressure: one transfer in flight; req_ready low until the response is consumed.
// Ports: PCLK/PRESET (sync, active-high); req_* request channel; rsp_* response
//        channel (held until rsp_ready); P* APB4 master bus with per-slave
//        PREADY/PRDATA/PSLVERR.
module apb_master_gen2
  import apb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_strb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         rsp_timeout,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic                         PWRITE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int SEL_W  = sel_w(NUM_SLAVES);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT != 0);
  // Terminal count: the ACCESS cycle with this count is the last one allowed.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  apb_state_t         state, state_nxt;
  logic [SEL_W-1:0]   idx_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               accept;
  logic               done_ok;
  logic               done_to;
  logic               sel_ready;
  logic               sel_err;
  logic [DATA_W-1:0]  sel_rdata;
  logic [SEL_W-1:0]   req_idx;

  assign req_idx = req_addr[ADDR_W-1 -: SEL_W];

  apb_rsp_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_W     (DATA_W),
    .SEL_W      (SEL_W)
  ) u_rsp_mux (
    .idx       (idx_q),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR),
    .sel_ready (sel_ready),
    .sel_rdata (sel_rdata),
    .sel_err   (sel_err)
  );

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus single-cycle event strobes for the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        // A slave completing on the terminal cycle beats the timeout.
        if (sel_ready) begin
          done_ok   = 1'b1;
          state_nxt = RESP;
        end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
          done_to   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs are computed from state_nxt so each one lines up with
  // the state it describes, without any combinational path to a port.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= '0;
      PENABLE     <= 1'b0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      idx_q       <= '0;
      wait_cnt    <= '0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      PENABLE   <= (state_nxt == ACCESS);

      if (accept) begin
        PADDR  <= req_addr;
        PWRITE <= req_write;
        PWDATA <= req_wdata;
        PSTRB  <= req_write ? req_strb : STRB_W'(0);
        idx_q  <= req_idx;
        PSEL   <= NUM_SLAVES'(1) << req_idx;
      end else if ((state_nxt == RESP) || (state_nxt == IDLE)) begin
        PSEL <= '0;
      end

      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && (state_nxt == ACCESS)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      if (done_ok) begin
        {rsp_timeout, rsp_err} <= sel_err ? RSP_SLVERR : RSP_OKAY;
        rsp_rdata <= (!PWRITE && !sel_err) ? sel_rdata : '0;
      end else if (done_to) begin
        {rsp_timeout, rsp_err} <= RSP_TIMEOUT;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_gen2.sv
// Self-checking bench for apb_master_gen2 with a behavioural APB slave array.
// Latency: n/a.
// Backpressure: response backpressure driven by the stimulus tasks.
module tb_apb_master_gen2;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int NUM_SLAVES = 4;
  localparam int TIMEOUT    = 16;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        to;
  } exp_t;

  logic                         PCLK = 1'b0;
  logic                         PRESET;
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [ADDR_W-1:0]            req_addr;
  logic [DATA_W-1:0]            req_wdata;
  logic [DATA_W/8-1:0]          req_strb;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [DATA_W-1:0]            rsp_rdata;
  logic                         rsp_err;
  logic                         rsp_timeout;
  logic [NUM_SLAVES-1:0]        PSEL;
  logic                         PENABLE;
  logic [ADDR_W-1:0]            PADDR;
  logic                         PWRITE;
  logic [DATA_W-1:0]            PWDATA;
  logic [DATA_W/8-1:0]          PSTRB;
  logic [NUM_SLAVES-1:0]        PREADY;
  logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]        PSLVERR;

  int    n_cmp = 0;
  int    n_err = 0;
  exp_t  sb[$];
  exp_t  mon_e;

  // Slave model knobs, set per transfer.
  int          wait_st = 0;
  logic        hang    = 1'b0;
  logic [31:0] rd_val  = '0;
  logic        err_val = 1'b0;
  int          acc_cnt;

  always #5 PCLK = ~PCLK;

  apb_master_gen2 #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_SLAVES (NUM_SLAVES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PADDR       (PADDR),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PREADY      (PREADY),
    .PRDATA      (PRDATA),
    .PSLVERR     (PSLVERR)
  );

  // Counts ACCESS cycles of the current transfer (0 in the first one).
  always @(posedge PCLK) begin
    if (PRESET) acc_cnt <= 0;
    else if (PENABLE && (|PSEL)) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  // Unselected slaves shout ready/error/garbage so any leak through the mux shows.
  always_comb begin
    PREADY  = '0;
    PRDATA  = '0;
    PSLVERR = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (PSEL[i]) begin
        PREADY[i]              = PENABLE && (acc_cnt >= wait_st) && !hang;
        PRDATA[i*DATA_W +: DATA_W] = rd_val;
        PSLVERR[i]             = err_val;
      end else begin
        PREADY[i]              = 1'b1;
        PRDATA[i*DATA_W +: DATA_W] = 32'hBAD0_0000 | i;
        PSLVERR[i]             = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: compares at every response handshake.
  always @(negedge PCLK) begin
    if (!PRESET && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexp_rsp", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rd);
        chk("rsp_err", rsp_err, mon_e.err);
        chk("rsp_timeout", rsp_timeout, mon_e.to);
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int ws, input logic hng,
                         input logic [31:0] rdv, input logic ev, input int hold,
                         input logic keep);
    exp_t       e;
    int         bud;
    int         n_acc;
    int         bad;
    logic [3:0] exp_sel;
    logic [3:0] exp_strb;
    exp_sel  = 4'b0001 << addr[7:6];
    exp_strb = wr ? st : 4'h0;
    e.rd  = hng ? 32'h0 : ((!wr && !ev) ? rdv : 32'h0);
    e.err = hng | ev;
    e.to  = hng;
    wait_st = ws; hang = hng; rd_val = rdv; err_val = ev;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_strb = st;
    bud = 0;
    while (!req_ready && bud < 50) begin
      tick();
      bud++;
    end
    chk("hs_ready", req_ready, 1);
    sb.push_back(e);
    tick();
    if (!keep) req_valid = 1'b0;
    chk("setup_psel", PSEL, exp_sel);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, addr);
    chk("setup_pwrite", PWRITE, wr);
    chk("setup_pwdata", PWDATA, wd);
    chk("setup_pstrb", PSTRB, exp_strb);
    chk("busy_req_ready", req_ready, 0);
    tick();
    n_acc = 0;
    bad = 0;
    while (PENABLE && n_acc < 100) begin
      if (PSEL !== exp_sel || PADDR !== addr || PSTRB !== exp_strb || PWDATA !== wd) bad++;
      n_acc++;
      tick();
    end
    chk("access_stable", bad, 0);
    chk("access_cycles", n_acc, hng ? TIMEOUT : ws + 1);
    chk("resp_psel", PSEL, 0);
    chk("resp_valid", rsp_valid, 1);
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rd || rsp_err !== e.err ||
          rsp_timeout !== e.to || req_ready !== 1'b0 || PSEL !== 4'h0) bad++;
      tick();
    end
    if (hold > 0) chk("hold_stable", bad, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bud;
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pstrb", PSTRB, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", {rsp_timeout, rsp_err}, 0);
    chk("rst_req_ready", req_ready, 0);
    PRESET = 1'b0;
    tick();
    chk("rdy_after_rst", req_ready, 1);

    //      wr    addr   wdata          strb  ws  hang  rdata          err   hold keep
    do_xfer(1'b1, 8'h45, 32'hDEADBEEF, 4'hF, 0,  1'b0, 32'h0,         1'b0, 0,   1'b0);
    do_xfer(1'b0, 8'hC0, 32'h0,        4'hF, 3,  1'b0, 32'h12345678,  1'b0, 0,   1'b0);
    do_xfer(1'b0, 8'h80, 32'h0,        4'h0, 1,  1'b0, 32'hCAFEF00D,  1'b1, 0,   1'b0);
    do_xfer(1'b0, 8'h10, 32'h0,        4'h0, 0,  1'b1, 32'h55555555,  1'b0, 0,   1'b0);
    do_xfer(1'b0, 8'hA4, 32'h0,        4'h0, 15, 1'b0, 32'h0000A5A5,  1'b0, 0,   1'b0);
    do_xfer(1'b1, 8'h3C, 32'h01020304, 4'h5, 2,  1'b0, 32'hFFFFFFFF,  1'b0, 5,   1'b1);
    do_xfer(1'b0, 8'h44, 32'h0,        4'h0, 0,  1'b0, 32'h87654321,  1'b0, 0,   1'b0);
    do_xfer(1'b1, 8'hFF, 32'h0BADCAFE, 4'h9, 0,  1'b0, 32'h11111111,  1'b1, 2,   1'b0);

    // Reset in the middle of ACCESS: transfer abandoned, no response.
    wait_st = 0; hang = 1'b1; rd_val = 32'h77777777; err_val = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h48; req_wdata = 32'hA5A5A5A5; req_strb = 4'hF;
    bud = 0;
    while (!req_ready && bud < 50) begin
      tick();
      bud++;
    end
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_penable", PENABLE, 1);
    PRESET = 1'b1;
    tick();
    chk("mrst_psel", PSEL, 0);
    chk("mrst_penable", PENABLE, 0);
    chk("mrst_paddr", PADDR, 0);
    chk("mrst_pwrite", PWRITE, 0);
    chk("mrst_pwdata", PWDATA, 0);
    chk("mrst_pstrb", PSTRB, 0);
    chk("mrst_rsp_valid", rsp_valid, 0);
    PRESET = 1'b0;
    hang = 1'b0;
    tick();
    chk("mrst_req_ready", req_ready, 1);
    repeat (3) tick();
    chk("mrst_no_rsp", rsp_valid, 0);
    do_xfer(1'b1, 8'h81, 32'h13572468, 4'hC, 1, 1'b0, 32'h0, 1'b0, 0, 1'b0);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
